m_tick_ctrl: RTL and testbench
==============================

Name: m_tick_ctrl

Overview:
- Programmable timer controller that replaces the fixed divide-by-constant toggle generator.
- Accepts a command (period, repeat count, mode) over a valid/ready handshake and sequences a phase counter.
- Emits a 1-cycle tick and a toggling square-wave output.
- Sits between a host/FSM issuing timing requests and LED/strobe consumers that need a divided clock-enable.

Parameters:
- PW, 32, width of period field and phase counter.
- CW, 16, width of repeat-count field and remaining counter.

Ports:
- w_clk  input  1  system clock, all state on rising edge.
- w_rst_n  input  1  asynchronous active-low reset.
- w_cmd_valid  input  1  command present.
- r_cmd_ready  output  1  controller can accept a command (high only in IDLE).
- w_cmd_period  input  PW  ticks period in cycles; 0 is treated as 1.
- w_cmd_count  input  CW  number of ticks for one-shot mode.
- w_cmd_mode  input  1  0 = one-shot (count ticks), 1 = continuous until stop.
- w_stop  input  1  synchronous abort request.
- r_tick  output  1  one-cycle pulse per elapsed period.
- r_out  output  1  toggles on every tick.
- r_done  output  1  one-cycle pulse on completion of a one-shot run.
- r_busy  output  1  high while in RUN.
- r_remaining  output  CW  ticks left in the current one-shot run.

Behaviour:
- Async reset (w_rst_n=0), effective immediately, also mid-run: state IDLE; r_cmd_ready=1 once reset releases; r_tick, r_out, r_done, r_busy=0; r_remaining=0; phase=0.
- States: IDLE, RUN. Transitions:
  - IDLE->RUN on edge with w_cmd_valid & r_cmd_ready.
  - RUN->IDLE on last one-shot tick or on w_stop.
- Accept: latch limit = (period==0 ? 1 : period), mode, and remaining = count. Set phase=0, r_busy=1, r_cmd_ready=0.
- One-shot with count==0: accept, then return to IDLE on the next edge. No tick is generated; r_done pulses for 1 cycle.
- RUN phase counter increments each cycle. At the edge where phase==limit-1:
  - phase<=0, r_tick<=1 for exactly one cycle, r_out<=~r_out.
  - In one-shot mode, remaining decrements.
- Latency: the first r_tick is high in the cycle beginning limit edges after the accept edge. Subsequent ticks are spaced exactly limit cycles apart.
- limit==1: r_tick stays high continuously; r_out toggles every cycle.
- One-shot end: on the edge producing the tick that brings remaining to 0:
  - r_done=1 in the same cycle as that r_tick.
  - Return to IDLE; r_busy=0 and r_cmd_ready=1 in that cycle.
  - A new command may be accepted at the following edge.
- w_stop in RUN has priority over a coincident tick. On that edge: no tick, no toggle, no r_done, remaining cleared to 0, state IDLE. r_out holds its level.
- w_stop in IDLE is ignored. w_stop and w_cmd_valid in the same IDLE cycle: the command is accepted.
- w_cmd_valid in RUN is ignored. The requester holds the command until ready.
- r_out is never cleared by a new command; it continues from its current level.
- Continuous mode: remaining is not decremented and r_done never pulses.
- Arithmetic: phase is unsigned PW bits and never exceeds limit-1. remaining is unsigned CW bits, max 2^CW-1, never decremented below 0.

Decomposition:
- Shared package m_tick_pkg: state encodings (ST_IDLE, ST_RUN) and mode constants (MODE_ONESHOT=0, MODE_CONT=1).
- One sub-module, m_phase_cnt (PW):
  - Inputs: clear, enable, limit.
  - Output: wrap pulse when phase==limit-1; phase wraps to 0.
  - The controller FSM instantiates it and owns remaining, r_out and the handshake.

Test Plan:
- Reset mid-run: period=5 continuous, assert w_rst_n=0 at cycle 7 -> all outputs 0 immediately; r_cmd_ready=1 after release.
- One-shot: period=4, count=3, mode=0 -> r_tick at cycles 4, 8, 12 after accept; r_out toggles 3 times; r_done coincident with 3rd tick; r_remaining 3->2->1->0.
- Period edge cases: period=0 and period=1, count=4 -> tick in 4 consecutive cycles, r_out toggles each cycle. Then count=0 -> r_done 1 cycle after accept, zero ticks.
- Continuous + stop: period=3, mode=1, w_stop asserted on a cycle where phase==2 -> no tick that edge, r_done stays 0, r_busy=0 next cycle, r_out unchanged.
- Handshake: w_cmd_valid held during RUN with a different period -> ignored until IDLE, then accepted at the first edge with ready=1. Back-to-back one-shot commands show exactly 1 idle accept cycle between runs.

Source files
------------

// File: rtl/m_tick_pkg.sv
// rtl/m_tick_pkg.sv - shared state and mode encodings for the programmable tick controller
package m_tick_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_CONT    = 1'b1;

endpackage

// File: rtl/m_phase_cnt.sv
// rtl/m_phase_cnt.sv - free-running phase counter that wraps and pulses at limit-1
module m_phase_cnt #(
    parameter int PW = 32
) (
    input  logic          w_clk,
    input  logic          w_rst_n,
    input  logic          clear,
    input  logic          enable,
    input  logic [PW-1:0] limit,
    output logic          wrap
);

    localparam logic [PW-1:0] ONE = PW'(1);

    logic [PW-1:0] phase;

    // clear wins so an abort or idle cycle never reports a wrap
    assign wrap = enable && !clear && (phase == limit - ONE);

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            phase <= '0;
        end else if (clear) begin
            phase <= '0;
        end else if (enable) begin
            phase <= wrap ? '0 : phase + ONE;
        end
    end

endmodule

// File: rtl/m_tick_ctrl.sv
// rtl/m_tick_ctrl.sv - programmable timer: accepts period/count/mode commands, emits tick and square wave
module m_tick_ctrl
    import m_tick_pkg::*;
#(
    parameter int PW = 32,
    parameter int CW = 16
) (
    input  logic          w_clk,
    input  logic          w_rst_n,
    input  logic          w_cmd_valid,
    output logic          r_cmd_ready,
    input  logic [PW-1:0] w_cmd_period,
    input  logic [CW-1:0] w_cmd_count,
    input  logic          w_cmd_mode,
    input  logic          w_stop,
    output logic          r_tick,
    output logic          r_out,
    output logic          r_done,
    output logic          r_busy,
    output logic [CW-1:0] r_remaining
);

    localparam logic [PW-1:0] LIM_ONE = PW'(1);
    localparam logic [CW-1:0] REM_ONE = CW'(1);

    state_t        state, state_nxt;
    logic          mode, mode_nxt;
    logic [PW-1:0] limit, limit_nxt;
    logic [CW-1:0] rem_nxt;
    logic          tick_nxt, out_nxt, done_nxt;
    logic          run, os_empty, wrap;

    assign run         = (state == ST_RUN);
    assign r_busy      = run;
    assign r_cmd_ready = w_rst_n && (state == ST_IDLE);
    // a one-shot run with nothing left finishes without ever ticking
    assign os_empty    = run && (mode == MODE_ONESHOT) && (r_remaining == '0);

    m_phase_cnt #(.PW(PW)) u_phase_cnt (
        .w_clk   (w_clk),
        .w_rst_n (w_rst_n),
        .clear   (!run || w_stop),
        .enable  (run && !os_empty),
        .limit   (limit),
        .wrap    (wrap)
    );

    always_comb begin
        state_nxt = state;
        mode_nxt  = mode;
        limit_nxt = limit;
        rem_nxt   = r_remaining;
        out_nxt   = r_out;
        tick_nxt  = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (w_cmd_valid && r_cmd_ready) begin
                    state_nxt = ST_RUN;
                    mode_nxt  = w_cmd_mode;
                    limit_nxt = (w_cmd_period == '0) ? LIM_ONE : w_cmd_period;
                    rem_nxt   = w_cmd_count;
                end
            end
            ST_RUN: begin
                if (w_stop) begin
                    state_nxt = ST_IDLE;
                    rem_nxt   = '0;
                end else if (os_empty) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end else if (wrap) begin
                    tick_nxt = 1'b1;
                    out_nxt  = !r_out;
                    if (mode == MODE_ONESHOT) begin
                        rem_nxt = r_remaining - REM_ONE;
                        if (r_remaining == REM_ONE) begin
                            state_nxt = ST_IDLE;
                            done_nxt  = 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state       <= ST_IDLE;
            mode        <= MODE_ONESHOT;
            limit       <= LIM_ONE;
            r_remaining <= '0;
            r_out       <= 1'b0;
            r_tick      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            state       <= state_nxt;
            mode        <= mode_nxt;
            limit       <= limit_nxt;
            r_remaining <= rem_nxt;
            r_out       <= out_nxt;
            r_tick      <= tick_nxt;
            r_done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_m_tick_ctrl.sv
// tb/tb_m_tick_ctrl.sv - self-checking bench for m_tick_ctrl against an elapsed-time reference model
module tb_m_tick_ctrl;

    logic        w_clk = 1'b0;
    logic        w_rst_n = 1'b0;
    logic        w_cmd_valid = 1'b0;
    logic        r_cmd_ready;
    logic [31:0] w_cmd_period = '0;
    logic [15:0] w_cmd_count = '0;
    logic        w_cmd_mode = 1'b0;
    logic        w_stop = 1'b0;
    logic        r_tick, r_out, r_done, r_busy;
    logic [15:0] r_remaining;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: a run is described by its accept edge, limit, count and mode
    longint edge_n = 0;
    longint acc_n  = 0;
    longint m_limit = 1;
    longint m_count = 0;
    bit     m_mode = 0;
    bit     m_run = 0;
    bit     m_out = 0;
    bit     e_tick = 0;
    bit     e_done = 0;
    longint m_rem = 0;
    bit     accepted = 0;

    always #5 w_clk = ~w_clk;

    m_tick_ctrl #(.PW(32), .CW(16)) dut (
        .w_clk        (w_clk),
        .w_rst_n      (w_rst_n),
        .w_cmd_valid  (w_cmd_valid),
        .r_cmd_ready  (r_cmd_ready),
        .w_cmd_period (w_cmd_period),
        .w_cmd_count  (w_cmd_count),
        .w_cmd_mode   (w_cmd_mode),
        .w_stop       (w_stop),
        .r_tick       (r_tick),
        .r_out        (r_out),
        .r_done       (r_done),
        .r_busy       (r_busy),
        .r_remaining  (r_remaining)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".tick"},  r_tick,      e_tick);
        check({tag, ".out"},   r_out,       m_out);
        check({tag, ".done"},  r_done,      e_done);
        check({tag, ".busy"},  r_busy,      m_run);
        check({tag, ".ready"}, r_cmd_ready, !m_run);
        check({tag, ".rem"},   r_remaining, m_rem[15:0]);
    endtask

    task automatic model_reset();
        m_run = 0; m_out = 0; e_tick = 0; e_done = 0; m_rem = 0;
    endtask

    task automatic step(input string tag);
        bit     v  = w_cmd_valid;
        bit     s  = w_stop;
        bit     md = w_cmd_mode;
        longint p  = w_cmd_period;
        longint c  = w_cmd_count;
        longint el, k;
        @(posedge w_clk);
        #1;
        edge_n++;
        accepted = 0;
        e_tick = 0;
        e_done = 0;
        if (m_run) begin
            el = edge_n - acc_n;
            if (s) begin
                m_run = 0;
                m_rem = 0;
            end else if (!m_mode && m_count == 0) begin
                m_run = 0;
                e_done = 1;
            end else if (el % m_limit == 0) begin
                k = el / m_limit;
                e_tick = 1;
                m_out = !m_out;
                if (!m_mode) begin
                    m_rem = m_count - k;
                    if (k == m_count) begin
                        m_run = 0;
                        e_done = 1;
                    end
                end
            end
        end else if (v) begin
            m_run = 1;
            accepted = 1;
            acc_n = edge_n;
            m_limit = (p == 0) ? 1 : p;
            m_count = c;
            m_rem = c;
            m_mode = md;
        end
        check_all(tag);
    endtask

    task automatic send(input logic [31:0] p, input logic [15:0] c, input logic md);
        bit ok = 0;
        w_cmd_valid = 1'b1;
        w_cmd_period = p;
        w_cmd_count = c;
        w_cmd_mode = md;
        for (int i = 0; i < 200; i++) begin
            step("accept");
            if (accepted) begin
                ok = 1;
                break;
            end
        end
        w_cmd_valid = 1'b0;
        check("accept_timeout", ok, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 0;
        for (int i = 0; i < 400; i++) begin
            if (!m_run) begin
                ok = 1;
                break;
            end
            step(tag);
        end
        check({tag, "_timeout"}, ok, 1'b1);
    endtask

    task automatic stop_now(input string tag);
        w_stop = 1'b1;
        step(tag);
        w_stop = 1'b0;
    endtask

    initial begin
        #12;
        check("reset.tick", r_tick, 1'b0);
        check("reset.out",  r_out,  1'b0);
        check("reset.busy", r_busy, 1'b0);
        check("reset.rem",  r_remaining, 16'd0);
        check("reset.ready_low", r_cmd_ready, 1'b0);
        w_rst_n = 1'b1;
        #1;
        check("reset.ready_rel", r_cmd_ready, 1'b1);
        model_reset();
        step("idle");

        // mid-run reset
        send(32'd5, 16'd0, 1'b1);
        for (int i = 0; i < 7; i++) step("cont5");
        #2 w_rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_mid.tick",  r_tick, 1'b0);
        check("rst_mid.out",   r_out, 1'b0);
        check("rst_mid.done",  r_done, 1'b0);
        check("rst_mid.busy",  r_busy, 1'b0);
        check("rst_mid.rem",   r_remaining, 16'd0);
        check("rst_mid.ready", r_cmd_ready, 1'b0);
        #3 w_rst_n = 1'b1;
        #1;
        check("rst_rel.ready", r_cmd_ready, 1'b1);
        step("post_rst");

        // one-shot period 4 count 3
        send(32'd4, 16'd3, 1'b0);
        wait_idle("os4x3");
        step("os4x3_after");

        // period edge cases
        send(32'd0, 16'd4, 1'b0);
        wait_idle("p0x4");
        send(32'd1, 16'd4, 1'b0);
        wait_idle("p1x4");
        send(32'd1, 16'd0, 1'b0);
        wait_idle("cnt0");
        step("cnt0_after");

        // continuous with stop while phase==2
        send(32'd3, 16'd0, 1'b1);
        step("cont3");
        step("cont3");
        stop_now("cont3_stop");
        step("cont3_idle");
        stop_now("stop_in_idle");

        // stop and command together in IDLE: command wins
        w_stop = 1'b1;
        send(32'd2, 16'd2, 1'b0);
        w_stop = 1'b0;
        wait_idle("stop_cmd");

        // command held during RUN, then back-to-back one-shots
        send(32'd3, 16'd2, 1'b0);
        send(32'd5, 16'd1, 1'b0);
        send(32'd2, 16'd2, 1'b0);
        wait_idle("b2b");

        // randomized commands
        for (int r = 0; r < 25; r++) begin
            logic [31:0] p;
            logic [15:0] c;
            logic md;
            p = 32'($urandom_range(0, 6));
            c = 16'($urandom_range(0, 4));
            md = 1'($urandom_range(0, 1));
            send(p, c, md);
            if (md || $urandom_range(0, 3) == 0) begin
                int n = $urandom_range(0, 12);
                for (int i = 0; i < n; i++) step("rnd_run");
                stop_now("rnd_stop");
            end else begin
                wait_idle("rnd_os");
            end
            if ($urandom_range(0, 1) == 1) step("rnd_gap");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
